// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: register-file geometry and the
// write-back result-select encoding.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  // x0 is never a real destination, so it never gets a bit.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] bits;
    bits = '0;
    if (rd != '0) bits[rd] = 1'b1;
    return bits;
  endfunction

endpackage

// File: rtl/wb_lu_fifo.sv
// Circular buffer for long-latency-unit results waiting for the shared
// register-file write port; also keeps a registered mask of pending rds.
module wb_lu_fifo
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [NUM_REGS-1:0] mask_reg, mask_next;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_vec;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_vec;
  logic [DEPTH-1:0][NUM_REGS-1:0]   entry_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_reg == CNT_W'(DEPTH));
  assign empty = (cnt_reg == '0);

  always_comb begin
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    cnt_next    = cnt_reg;
    if (push && !pop)      cnt_next = cnt_reg + 1'b1;
    else if (pop && !push) cnt_next = cnt_reg - 1'b1;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic                  valid_reg;
      logic [REG_ADDR_W-1:0] rd_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  hit_push, hit_pop, valid_next;
      logic [REG_ADDR_W-1:0] rd_next;

      assign hit_push = push && (wr_ptr_reg == PTR_W'(gi));
      assign hit_pop  = pop  && (rd_ptr_reg == PTR_W'(gi));
      // When full, push and pop hit the same slot; the push must win.
      assign valid_next = hit_push || (valid_reg && !hit_pop);
      assign rd_next    = hit_push ? push_rd : rd_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          rd_reg    <= '0;
          data_reg  <= '0;
        end else if (hit_push) begin
          valid_reg <= 1'b1;
          rd_reg    <= push_rd;
          data_reg  <= push_data;
        end else if (hit_pop) begin
          valid_reg <= 1'b0;
        end
      end

      assign rd_vec[gi]     = rd_reg;
      assign data_vec[gi]   = data_reg;
      assign entry_mask[gi] = valid_next ? rd_onehot(rd_next) : '0;
    end
  endgenerate

  always_comb begin
    mask_next = '0;
    for (int i = 0; i < DEPTH; i++) mask_next = mask_next | entry_mask[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
      mask_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      cnt_reg    <= cnt_next;
      mask_reg   <= mask_next;
    end
  end

  assign head_rd      = rd_vec[rd_ptr_reg];
  assign head_data    = data_vec[rd_ptr_reg];
  assign pending_mask = mask_reg;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, result select, and fixed-priority
// arbitration of the register-file write port between pipeline and LU buffer.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LU_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [1:0]            mem_wb_sel,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_load_data,
  input  logic [ADDR_WIDTH-1:0] mem_pc_plus_4,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd_addr,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  lu_ready,
  output logic                  wb_reg_write_en,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic [DATA_WIDTH-1:0] wb_rd_data,
  output logic                  wb_stall_req,
  output logic [NUM_REGS-1:0]   lu_pending_mask
);

  logic                  valid_reg;
  logic                  written_reg;
  logic                  reg_write_reg;
  logic [1:0]            wb_sel_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [DATA_WIDTH-1:0] alu_reg;
  logic [DATA_WIDTH-1:0] load_reg;
  logic [ADDR_WIDTH-1:0] pc4_reg;

  logic                  pipe_cand;
  logic [DATA_WIDTH-1:0] pipe_result;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;

  assign pipe_cand = valid_reg && reg_write_reg && (rd_reg != '0) && !written_reg;

  // A stalled entry that already wrote must not write again.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      written_reg   <= 1'b0;
      reg_write_reg <= 1'b0;
      wb_sel_reg    <= '0;
      rd_reg        <= '0;
      alu_reg       <= '0;
      load_reg      <= '0;
      pc4_reg       <= '0;
    end else if (flush) begin
      valid_reg   <= 1'b0;
      written_reg <= 1'b0;
    end else if (stall) begin
      written_reg <= written_reg || pipe_cand;
    end else begin
      valid_reg     <= mem_valid;
      written_reg   <= 1'b0;
      reg_write_reg <= mem_reg_write;
      wb_sel_reg    <= mem_wb_sel;
      rd_reg        <= mem_rd_addr;
      alu_reg       <= mem_alu_result;
      load_reg      <= mem_load_data;
      pc4_reg       <= mem_pc_plus_4;
    end
  end

  always_comb begin
    pipe_result = alu_reg;
    case (wb_sel_reg)
      WB_LOAD: pipe_result = load_reg;
      WB_PC4:  pipe_result = DATA_WIDTH'(pc4_reg);
      default: pipe_result = alu_reg;
    endcase
  end

  assign fifo_pop  = !pipe_cand && !fifo_empty;
  assign lu_ready  = !rst && (!fifo_full || fifo_pop);
  // x0 results are acknowledged but never occupy a slot.
  assign fifo_push = lu_valid && lu_ready && (lu_rd_addr != '0);

  wb_lu_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (LU_DEPTH)
  ) u_lu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_rd     (lu_rd_addr),
    .push_data   (lu_data),
    .pop         (fifo_pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .pending_mask(lu_pending_mask)
  );

  always_comb begin
    wb_reg_write_en = 1'b0;
    wb_rd_addr      = '0;
    wb_rd_data      = '0;
    if (pipe_cand) begin
      wb_reg_write_en = 1'b1;
      wb_rd_addr      = rd_reg;
      wb_rd_data      = pipe_result;
    end else if (fifo_pop) begin
      wb_reg_write_en = 1'b1;
      wb_rd_addr      = head_rd;
      wb_rd_data      = head_data;
    end
  end

  assign wb_stall_req = fifo_full;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// against a queue-based reference model of the write-back rules.
module tb_wb_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, mem_reg_write;
  logic [1:0]    mem_wb_sel;
  logic [4:0]    mem_rd_addr;
  logic [DW-1:0] mem_alu_result, mem_load_data;
  logic [AW-1:0] mem_pc_plus_4;
  logic          stall, flush;
  logic          lu_valid;
  logic [4:0]    lu_rd_addr;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          wb_reg_write_en;
  logic [4:0]    wb_rd_addr;
  logic [DW-1:0] wb_rd_data;
  logic          wb_stall_req;
  logic [31:0]   lu_pending_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LU_DEPTH(LD)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
    .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc_plus_4(mem_pc_plus_4),
    .stall(stall), .flush(flush),
    .lu_valid(lu_valid), .lu_rd_addr(lu_rd_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .wb_reg_write_en(wb_reg_write_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .wb_stall_req(wb_stall_req), .lu_pending_mask(lu_pending_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_reg_write = 0; mem_wb_sel = 2'b00; mem_rd_addr = 0;
    mem_alu_result = 0; mem_load_data = 0; mem_pc_plus_4 = 0;
    stall = 0; flush = 0; lu_valid = 0; lu_rd_addr = 0; lu_data = 0;
  endtask

  task automatic set_mem(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc4);
    mem_valid = 1; mem_reg_write = 1; mem_wb_sel = sel; mem_rd_addr = rd;
    mem_alu_result = alu; mem_load_data = ld; mem_pc_plus_4 = pc4;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    n_cmp++; if ({wb_reg_write_en, wb_rd_addr, wb_rd_data} !== 38'd0) begin n_bad++; $display("FAIL reset_port got %b/%0d/%h want 0/0/0", wb_reg_write_en, wb_rd_addr, wb_rd_data); end
    n_cmp++; if ({wb_stall_req, lu_pending_mask} !== 33'd0) begin n_bad++; $display("FAIL reset_stall_mask got %b/%h want 0/0", wb_stall_req, lu_pending_mask); end
    n_cmp++; if (lu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low got %b want 0", lu_ready); end
    rst = 0; #1;
    n_cmp++; if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got %b want 1", lu_ready); end
  endtask

  task automatic test_load();
    set_mem(2'b01, 5'd5, 32'h1111, 32'hDEADBEEF, 32'h0);
    tick();
    n_cmp++; if ({wb_reg_write_en, wb_rd_addr, wb_rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_bad++; $display("FAIL load_write got %b/%0d/%h want 1/5/deadbeef", wb_reg_write_en, wb_rd_addr, wb_rd_data); end
    mem_rd_addr = 0;
    tick();
    n_cmp++; if (wb_reg_write_en !== 1'b0) begin n_bad++; $display("FAIL load_x0 got en=%b want 0", wb_reg_write_en); end
    idle_inputs(); tick();
  endtask

  task automatic test_stall_flush();
    int writes;
    set_mem(2'b00, 5'd3, 32'h10, 32'h0, 32'h0);
    tick();
    stall = 1;
    writes = wb_reg_write_en ? 1 : 0;
    n_cmp++; if ({wb_rd_addr, wb_rd_data} !== {5'd3, 32'h10}) begin n_bad++; $display("FAIL stall_first got %0d/%h want 3/10", wb_rd_addr, wb_rd_data); end
    for (int i = 0; i < 3; i++) begin
      mem_rd_addr = 5'd9;
      tick();
      if (wb_reg_write_en) writes++;
    end
    n_cmp++; if (writes !== 1) begin n_bad++; $display("FAIL stall_once got %0d writes want 1", writes); end
    n_cmp++; if (wb_rd_addr !== 5'd3 && wb_reg_write_en) begin n_bad++; $display("FAIL stall_hold got rd=%0d want held 3", wb_rd_addr); end
    stall = 0; mem_rd_addr = 5'd3;
    tick();
    n_cmp++; if ({wb_reg_write_en, wb_rd_addr} !== {1'b1, 5'd3}) begin n_bad++; $display("FAIL stall_recapture got %b/%0d want 1/3", wb_reg_write_en, wb_rd_addr); end
    stall = 1; flush = 1; mem_rd_addr = 5'd4;
    tick();
    stall = 1; flush = 0;
    tick();
    n_cmp++; if (wb_reg_write_en !== 1'b0) begin n_bad++; $display("FAIL flush_stall got en=%b want 0", wb_reg_write_en); end
    idle_inputs(); tick();
  endtask

  task automatic test_lu_bubble();
    set_mem(2'b00, 5'd10, 32'hA0, 32'h0, 32'h0);
    tick();
    lu_valid = 1; lu_rd_addr = 5'd7; lu_data = 32'h55; mem_rd_addr = 5'd11; #1;
    n_cmp++; if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL lu_ready_empty got %b want 1", lu_ready); end
    tick();
    lu_valid = 0; mem_rd_addr = 5'd12;
    n_cmp++; if ({wb_reg_write_en, wb_rd_addr, lu_pending_mask[7]} !== {1'b1, 5'd11, 1'b1}) begin n_bad++; $display("FAIL lu_busy got %b/%0d/%b want 1/11/1", wb_reg_write_en, wb_rd_addr, lu_pending_mask[7]); end
    tick();
    mem_valid = 0;
    n_cmp++; if (wb_rd_addr !== 5'd12) begin n_bad++; $display("FAIL lu_pipe_prio got rd=%0d want 12", wb_rd_addr); end
    tick();
    n_cmp++; if ({wb_reg_write_en, wb_rd_addr, wb_rd_data} !== {1'b1, 5'd7, 32'h55}) begin n_bad++; $display("FAIL lu_bubble got %b/%0d/%h want 1/7/55", wb_reg_write_en, wb_rd_addr, wb_rd_data); end
    tick();
    n_cmp++; if ({wb_reg_write_en, lu_pending_mask} !== 33'd0) begin n_bad++; $display("FAIL lu_drained got %b/%h want 0/0", wb_reg_write_en, lu_pending_mask); end
  endtask

  task automatic test_back_to_back();
    set_mem(2'b00, 5'd12, 32'hC0, 32'h0, 32'h0);
    tick();
    lu_valid = 1; lu_rd_addr = 5'd8; lu_data = 32'h88; tick();
    lu_rd_addr = 5'd9; lu_data = 32'h99; tick();
    lu_rd_addr = 5'd10; lu_data = 32'hAA; #1;
    n_cmp++; if ({lu_ready, wb_stall_req} !== 2'b01) begin n_bad++; $display("FAIL full_flags got ready=%b stall=%b want 0/1", lu_ready, wb_stall_req); end
    n_cmp++; if (lu_pending_mask !== 32'h0000_0300) begin n_bad++; $display("FAIL full_mask got %h want 00000300", lu_pending_mask); end
    tick();
    mem_valid = 0;
    tick();
    n_cmp++; if ({wb_reg_write_en, wb_rd_addr, wb_rd_data, lu_ready} !== {1'b1, 5'd8, 32'h88, 1'b1}) begin n_bad++; $display("FAIL drain8 got %b/%0d/%h ready=%b want 1/8/88 ready=1", wb_reg_write_en, wb_rd_addr, wb_rd_data, lu_ready); end
    tick();
    lu_valid = 0;
    n_cmp++; if ({wb_rd_addr, wb_rd_data} !== {5'd9, 32'h99}) begin n_bad++; $display("FAIL drain9 got %0d/%h want 9/99", wb_rd_addr, wb_rd_data); end
    tick();
    n_cmp++; if ({wb_reg_write_en, wb_rd_addr, wb_rd_data} !== {1'b1, 5'd10, 32'hAA}) begin n_bad++; $display("FAIL drain10 got %b/%0d/%h want 1/10/aa", wb_reg_write_en, wb_rd_addr, wb_rd_data); end
    tick();
    n_cmp++; if ({wb_reg_write_en, wb_stall_req} !== 2'b00) begin n_bad++; $display("FAIL drain_done got %b/%b want 0/0", wb_reg_write_en, wb_stall_req); end
  endtask

  task automatic test_reset_mid();
    set_mem(2'b00, 5'd20, 32'h1, 32'h0, 32'h0);
    tick();
    lu_valid = 1; lu_rd_addr = 5'd13; lu_data = 32'hD; tick();
    lu_rd_addr = 5'd14; lu_data = 32'hE; tick();
    lu_valid = 0; mem_valid = 0; rst = 1; #1;
    n_cmp++; if (lu_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready got %b want 0", lu_ready); end
    tick();
    rst = 0; #1;
    n_cmp++; if ({wb_reg_write_en, lu_pending_mask, lu_ready} !== {1'b0, 32'h0, 1'b1}) begin n_bad++; $display("FAIL rstmid_state got en=%b mask=%h ready=%b want 0/0/1", wb_reg_write_en, lu_pending_mask, lu_ready); end
    tick();
    n_cmp++; if (wb_reg_write_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_discard got en=%b rd=%0d want 0", wb_reg_write_en, wb_rd_addr); end
  endtask

  task automatic test_jal_sel3();
    set_mem(2'b10, 5'd1, 32'hBAD0, 32'hBAD1, 32'h104);
    tick();
    n_cmp++; if ({wb_rd_addr, wb_rd_data} !== {5'd1, 32'h104}) begin n_bad++; $display("FAIL jal got %0d/%h want 1/104", wb_rd_addr, wb_rd_data); end
    set_mem(2'b11, 5'd2, 32'h777, 32'hBAD2, 32'hBAD3);
    tick();
    n_cmp++; if ({wb_rd_addr, wb_rd_data} !== {5'd2, 32'h777}) begin n_bad++; $display("FAIL sel3 got %0d/%h want 2/777", wb_rd_addr, wb_rd_data); end
    idle_inputs(); tick();
  endtask

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } lu_item_t;

  // Reference: a queue stands in for the LU buffer; the MEM/WB slot is a set of fields.
  task automatic test_random();
    lu_item_t q[$];
    bit m_valid, m_rw, m_written, cand, pop, ready;
    logic [1:0] m_sel; logic [4:0] m_rd; logic [31:0] m_alu, m_ld, m_pc4, m_res;
    logic [37:0] exp_port; logic [31:0] exp_mask;
    int bad_before;
    idle_inputs(); rst = 1; tick(); rst = 0;
    m_valid = 0; m_written = 0; m_rw = 0; m_sel = 0; m_rd = 0; m_alu = 0; m_ld = 0; m_pc4 = 0;
    bad_before = n_bad;
    for (int cyc = 0; cyc < 600; cyc++) begin
      mem_valid = ($urandom_range(0, 9) < 7); mem_reg_write = ($urandom_range(0, 9) < 8);
      mem_wb_sel = 2'($urandom_range(0, 3)); mem_rd_addr = 5'($urandom_range(0, 31));
      mem_alu_result = $urandom; mem_load_data = $urandom; mem_pc_plus_4 = $urandom;
      stall = ($urandom_range(0, 9) < 2); flush = ($urandom_range(0, 9) == 0);
      lu_valid = ($urandom_range(0, 9) < 5); lu_rd_addr = 5'($urandom_range(0, 31)); lu_data = $urandom;
      #1;
      m_res = (m_sel == 2'b01) ? m_ld : (m_sel == 2'b10) ? m_pc4 : m_alu;
      cand = m_valid && m_rw && (m_rd != 0) && !m_written;
      pop = !cand && (q.size() > 0);
      ready = (q.size() < LD) || pop;
      exp_port = cand ? {1'b1, m_rd, m_res} : pop ? {1'b1, q[0].rd, q[0].data} : 38'd0;
      exp_mask = 0;
      foreach (q[i]) exp_mask[q[i].rd] = 1'b1;
      n_cmp++; if ({wb_reg_write_en, wb_rd_addr, wb_rd_data} !== exp_port) begin n_bad++; $display("FAIL rnd_port cyc %0d got %b/%0d/%h want %b/%0d/%h", cyc, wb_reg_write_en, wb_rd_addr, wb_rd_data, exp_port[37], exp_port[36:32], exp_port[31:0]); end
      n_cmp++; if ({lu_ready, wb_stall_req, lu_pending_mask} !== {ready, q.size() == LD, exp_mask}) begin n_bad++; $display("FAIL rnd_lu cyc %0d got ready=%b stall=%b mask=%h want %b/%b/%h", cyc, lu_ready, wb_stall_req, lu_pending_mask, ready, q.size() == LD, exp_mask); end
      if (pop) void'(q.pop_front());
      if (lu_valid && ready && lu_rd_addr != 0) q.push_back('{rd: lu_rd_addr, data: lu_data});
      if (flush) begin m_valid = 0; m_written = 0; end
      else if (stall) m_written = m_written || cand;
      else begin
        m_valid = mem_valid; m_rw = mem_reg_write; m_sel = mem_wb_sel; m_rd = mem_rd_addr;
        m_alu = mem_alu_result; m_ld = mem_load_data; m_pc4 = mem_pc_plus_4; m_written = 0;
      end
      tick();
      if (n_bad - bad_before > 20) break;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall_flush();
    test_lu_bubble();
    test_back_to_back();
    test_reset_mid();
    test_jal_sel3();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
